// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//
// Y86-64 pipeline stage register placed between adjacent stages (F/D, D/E,
// E/M, M/W). Carries icode, ifun, NREG register-ID fields, NVAL value fields
// and the status code, with stall (hold) and bubble (nop inject) control.
// Also contains a consecutive-stall watchdog, a stall/bubble conflict flag
// and optional performance counters.
//
// Build option:
//   PIPE_STAGE_PERF_EN  defined   -> stall_cnt / bubble_cnt are live 32-bit
//                                    wrapping counters
//                       undefined -> both read as constant 0, no counter flops
//
// Ports:
//   clk            clock, all state updates on rising edge
//   rst_n          synchronous active-low reset
//   stall          hold current contents (wins over bubble)
//   bubble         load a nop on the next edge
//   icode_in       upstream icode
//   ifun_in        upstream ifun
//   reg_in         register IDs, field k at [4k+3:4k]
//   val_in         values, field k at [VW*k+VW-1:VW*k]
//   stat_in        upstream status
//   icode_out .. stat_out   registered copies of the inputs
//   valid_out      1 = real instruction held, 0 = bubble
//   stall_timeout  sticky, stall held STALL_MAX consecutive edges
//   ctrl_conflict  sticky, stall and bubble asserted on the same edge
//   stall_cnt      stalled edges (perf)
//   bubble_cnt     bubbles injected (perf)

module pipe_stage_reg #(
   parameter int           NREG         = 2,
   parameter int           NVAL         = 2,
   parameter int           VW           = 64,
   parameter logic [3:0]   BUBBLE_ICODE = 4'h1,
   parameter logic [2:0]   BUBBLE_STAT  = 3'd0,
   parameter int           STALL_MAX    = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stall,
   input  logic                 bubble,
   input  logic [3:0]           icode_in,
   input  logic [3:0]           ifun_in,
   input  logic [NREG*4-1:0]    reg_in,
   input  logic [NVAL*VW-1:0]   val_in,
   input  logic [2:0]           stat_in,
   output logic [3:0]           icode_out,
   output logic [3:0]           ifun_out,
   output logic [NREG*4-1:0]    reg_out,
   output logic [NVAL*VW-1:0]   val_out,
   output logic [2:0]           stat_out,
   output logic                 valid_out,
   output logic                 stall_timeout,
   output logic                 ctrl_conflict,
   output logic [31:0]          stall_cnt,
   output logic [31:0]          bubble_cnt
);

   localparam int               RUN_W    = $clog2(STALL_MAX + 1);
   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STALL_MAX);
   localparam logic [NREG*4-1:0] REG_NONE = {NREG{4'hF}};

   logic [RUN_W-1:0] stall_run;

   // Payload: reset and bubble load identical nop contents.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         icode_out <= BUBBLE_ICODE;
         ifun_out  <= 4'h0;
         reg_out   <= REG_NONE;
         val_out   <= '0;
         stat_out  <= BUBBLE_STAT;
         valid_out <= 1'b0;
      end else if (stall) begin
         icode_out <= icode_out;
         ifun_out  <= ifun_out;
         reg_out   <= reg_out;
         val_out   <= val_out;
         stat_out  <= stat_out;
         valid_out <= valid_out;
      end else if (bubble) begin
         icode_out <= BUBBLE_ICODE;
         ifun_out  <= 4'h0;
         reg_out   <= REG_NONE;
         val_out   <= '0;
         stat_out  <= BUBBLE_STAT;
         valid_out <= 1'b0;
      end else begin
         icode_out <= icode_in;
         ifun_out  <= ifun_in;
         reg_out   <= reg_in;
         val_out   <= val_in;
         stat_out  <= stat_in;
         valid_out <= 1'b1;
      end
   end

   // Watchdog: run length saturates at STALL_MAX; the timeout flag is set on
   // the edge that takes the run to STALL_MAX (or any later stalled edge).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_run     <= '0;
         stall_timeout <= 1'b0;
      end else if (stall) begin
         if (stall_run != RUN_MAX) begin
            stall_run <= stall_run + 1'b1;
         end
         if (stall_run >= RUN_MAX - 1'b1) begin
            stall_timeout <= 1'b1;
         end
      end else begin
         stall_run <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl_conflict <= 1'b0;
      end else if (stall && bubble) begin
         ctrl_conflict <= 1'b1;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] bubble_cnt_q;

   // A conflicting edge is a stall, so it counts as stalled, not bubbled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else if (stall) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end else if (bubble) begin
         bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`else
   assign stall_cnt  = 32'd0;
   assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic         stall;
   logic         bubble;
   logic [3:0]   icode_in;
   logic [3:0]   ifun_in;
   logic [7:0]   reg_in;
   logic [127:0] val_in;
   logic [2:0]   stat_in;
   logic [3:0]   icode_out;
   logic [3:0]   ifun_out;
   logic [7:0]   reg_out;
   logic [127:0] val_out;
   logic [2:0]   stat_out;
   logic         valid_out;
   logic         stall_timeout;
   logic         ctrl_conflict;
   logic [31:0]  stall_cnt;
   logic [31:0]  bubble_cnt;

   pipe_stage_reg dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .bubble        (bubble),
      .icode_in      (icode_in),
      .ifun_in       (ifun_in),
      .reg_in        (reg_in),
      .val_in        (val_in),
      .stat_in       (stat_in),
      .icode_out     (icode_out),
      .ifun_out      (ifun_out),
      .reg_out       (reg_out),
      .val_out       (val_out),
      .stat_out      (stat_out),
      .valid_out     (valid_out),
      .stall_timeout (stall_timeout),
      .ctrl_conflict (ctrl_conflict),
      .stall_cnt     (stall_cnt),
      .bubble_cnt    (bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]   icode;
      logic [3:0]   ifun;
      logic [7:0]   regs;
      logic [127:0] val;
      logic [2:0]   stat;
      logic         valid;
      logic         to;
      logic         cf;
      logic [31:0]  sc;
      logic [31:0]  bc;
   } exp_t;

   exp_t q[$];
   exp_t m;
   int   run;
   int   n_cmp;
   int   n_bad;
   int   cyc_no;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %h want %h", name, cyc_no, act, req);
      end
   endtask

   // Monitor: one expected entry per clock edge, compared just after it.
   initial begin
      exp_t e;
      cyc_no = 0;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            cyc_no++;
            check("icode",    128'(icode_out),     128'(e.icode));
            check("ifun",     128'(ifun_out),      128'(e.ifun));
            check("reg",      128'(reg_out),       128'(e.regs));
            check("val",      val_out,             e.val);
            check("stat",     128'(stat_out),      128'(e.stat));
            check("valid",    128'(valid_out),     128'(e.valid));
            check("timeout",  128'(stall_timeout), 128'(e.to));
            check("conflict", 128'(ctrl_conflict), 128'(e.cf));
            check("stall_cnt",  128'(stall_cnt),   128'(e.sc));
            check("bubble_cnt", 128'(bubble_cnt),  128'(e.bc));
         end
      end
   end

   task automatic set_nop();
      m.icode = 4'h1;
      m.ifun  = 4'h0;
      m.regs  = 8'hFF;
      m.val   = '0;
      m.stat  = 3'd0;
      m.valid = 1'b0;
   endtask

   // Drive one edge's worth of inputs and queue the expected post-edge state.
   task automatic cyc(input logic r, input logic s, input logic b,
                      input logic [3:0] ic, input logic [3:0] fn,
                      input logic [7:0] rg, input logic [127:0] v,
                      input logic [2:0] st);
      rst_n    = r;
      stall    = s;
      bubble   = b;
      icode_in = ic;
      ifun_in  = fn;
      reg_in   = rg;
      val_in   = v;
      stat_in  = st;
      if (!r) begin
         set_nop();
         m.to = 1'b0;
         m.cf = 1'b0;
         m.sc = '0;
         m.bc = '0;
         run  = 0;
      end else if (s) begin
         run = (run < 15) ? run + 1 : 15;
         if (run == 15) m.to = 1'b1;
         if (b) m.cf = 1'b1;
         if (PERF) m.sc = m.sc + 32'd1;
      end else if (b) begin
         set_nop();
         run = 0;
         if (PERF) m.bc = m.bc + 32'd1;
      end else begin
         m.icode = ic;
         m.ifun  = fn;
         m.regs  = rg;
         m.val   = v;
         m.stat  = st;
         m.valid = 1'b1;
         run     = 0;
      end
      q.push_back(m);
      @(negedge clk);
   endtask

   initial begin
      int guard;
      n_cmp = 0;
      n_bad = 0;
      m     = '0;
      run   = 0;
      rst_n = 1'b0; stall = 1'b0; bubble = 1'b0;
      icode_in = '0; ifun_in = '0; reg_in = '0; val_in = '0; stat_in = '0;
      @(negedge clk);

      // reset with junk on the data inputs
      cyc(0, 0, 0, 4'h7, 4'h3, 8'h12, {64'h55, 64'h66}, 3'd4);
      // load stream
      cyc(1, 0, 0, 4'h6, 4'h0, 8'h23, {64'hA, 64'hB}, 3'd1);
      // stall 3 with changing inputs
      cyc(1, 1, 0, 4'h2, 4'h1, 8'h45, {64'h1, 64'h2}, 3'd2);
      cyc(1, 1, 0, 4'h3, 4'h2, 8'h67, {64'h3, 64'h4}, 3'd3);
      cyc(1, 1, 0, 4'h4, 4'h3, 8'h89, {64'h5, 64'h6}, 3'd4);
      // load, bubble, load
      cyc(1, 0, 0, 4'h5, 4'h0, 8'h4F, {64'hDEAD_BEEF, 64'h1234_5678_9ABC_DEF0}, 3'd1);
      cyc(1, 0, 1, 4'h8, 4'h0, 8'hF0, {64'h7, 64'h8}, 3'd1);
      cyc(1, 0, 0, 4'h7, 4'h4, 8'hF3, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, 3'd1);
      // conflict: hold, sticky flag
      cyc(1, 1, 1, 4'h9, 4'h0, 8'h00, {64'h9, 64'h9}, 3'd2);
      cyc(1, 0, 0, 4'hA, 4'h0, 8'h01, {64'hA0, 64'hB0}, 3'd1);
      cyc(1, 0, 0, 4'hB, 4'h0, 8'h4F, {64'hC0, 64'hD0}, 3'd1);
      // 16 consecutive stalls: timeout appears after the 15th, run saturates
      for (int i = 0; i < 16; i++)
         cyc(1, 1, 0, 4'(i), 4'h5, 8'(i), {64'(i), 64'(i * 3)}, 3'd2);
      cyc(1, 0, 0, 4'hC, 4'h0, 8'hF4, {64'h11, 64'h22}, 3'd1);
      cyc(1, 0, 1, 4'hC, 4'h0, 8'hF4, {64'h11, 64'h22}, 3'd1);
      // reset clears stickies
      cyc(0, 0, 0, 4'h2, 4'h0, 8'h34, {64'h33, 64'h44}, 3'd1);
      // 14 stalls then release: no timeout, run restarts
      cyc(1, 0, 0, 4'h6, 4'h1, 8'h12, {64'h5, 64'h6}, 3'd1);
      for (int i = 0; i < 14; i++)
         cyc(1, 1, 0, 4'h0, 4'h0, 8'h00, {64'h0, 64'h0}, 3'd0);
      cyc(1, 0, 0, 4'h3, 4'h0, 8'h56, {64'h77, 64'h88}, 3'd1);
      cyc(1, 1, 0, 4'h4, 4'h0, 8'h56, {64'h77, 64'h88}, 3'd1);
      // reset mid-stall and mid-bubble
      cyc(0, 1, 0, 4'h4, 4'h0, 8'h56, {64'h77, 64'h88}, 3'd1);
      cyc(1, 0, 0, 4'h6, 4'h2, 8'h9A, {64'h99, 64'hAA}, 3'd1);
      cyc(0, 0, 1, 4'h6, 4'h2, 8'h9A, {64'h99, 64'hAA}, 3'd1);
      cyc(1, 0, 0, 4'h6, 4'h3, 8'hBC, {64'hBB, 64'hCC}, 3'd1);

      guard = 0;
      while (q.size() > 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d entries left want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised Y86-64 pipeline stage register: one instance sits between each pair of adjacent stages (F/D, D/E, E/M, M/W). It carries icode, ifun, a configurable set of register-ID and 64-bit value fields, and the status code to the next stage. It supports stall (hold) and bubble (inject nop) control from the pipeline control logic. It also has a stall watchdog, a conflict detector and optional performance counters.

## Interface
Parameters:
- NREG, 2, number of 4-bit register-ID fields carried
- NVAL, 2, number of value fields carried
- VW, 64, width of each value field
- BUBBLE_ICODE, 4'h1, icode loaded on bubble/reset (nop)
- BUBBLE_STAT, 3'd0, stat loaded on bubble/reset
- STALL_MAX, 15, consecutive-stall threshold for watchdog (>=1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- stall  in  1  hold current contents
- bubble  in  1  load nop on next edge
- icode_in  in  4  upstream icode
- ifun_in  in  4  upstream ifun
- reg_in  in  NREG*4  register IDs; field k at [4k+3:4k]
- val_in  in  NVAL*VW  values; field k at [VW*k+VW-1:VW*k]
- stat_in  in  3  upstream status
- icode_out, ifun_out, reg_out, val_out, stat_out  out  same widths  registered copies
- valid_out  out  1  1 = real instruction held, 0 = bubble
- stall_timeout  out  1  sticky: stall held STALL_MAX consecutive cycles
- ctrl_conflict  out  1  sticky: stall and bubble asserted together
- stall_cnt  out  32  stalled cycles (perf)
- bubble_cnt  out  32  bubbles injected (perf)

## Operation
- Per-edge priority: reset > stall > bubble > load.
- Reset (rst_n=0 at edge): icode_out=BUBBLE_ICODE, ifun_out=0, every reg_out field=4'hF (RNONE), val_out=0, stat_out=BUBBLE_STAT, valid_out=0, stall_timeout=0, ctrl_conflict=0, stall_cnt=0, bubble_cnt=0, internal stall-run counter=0.
- Stall: all data outputs and valid_out hold.
- Bubble (stall=0): same data values as reset; valid_out=0; stickies unchanged.
- Load (stall=0, bubble=0): all outputs take their inputs; valid_out=1.
- Conflict: stall=1 and bubble=1 -> stall wins (hold); ctrl_conflict set.
- Watchdog: a stall-run counter of width $clog2(STALL_MAX+1) increments on each stalled edge and saturates at STALL_MAX. It clears on any non-stalled edge. stall_timeout sets on the edge where the counter reaches STALL_MAX. Stickies clear only on reset.
- Reset mid-stall or mid-bubble: reset wins; state is fully reinitialised.

## Timing
- Latency 1 cycle input to output; no combinational input-to-output paths.
- stall/bubble are sampled at the same edge as the data they qualify.
- stall_timeout rises at the end of the STALL_MAXth consecutive stalled cycle.
- ctrl_conflict rises 1 cycle after the offending edge is sampled, i.e. visible after that edge.
- Counters are visible on the edge following the event.

## Configuration
- PIPE_STAGE_PERF_EN defined: stall_cnt increments on every stalled edge (including conflicts). bubble_cnt increments on every edge where bubble takes effect. Both are 32-bit and wrap 0xFFFFFFFF->0.
- Not defined: stall_cnt and bubble_cnt are constant 0 and no counter flops are built. Ports remain present.

## Test plan
- Reset then idle: hold rst_n=0 one edge -> icode_out=4'h1, reg_out=8'hFF, val_out=0, stat_out=0, valid_out=0, all flags/counters 0.
- Load stream: icode_in=4'h6, ifun_in=4'h0, reg_in=8'h23, val_in={64'hA,64'hB}, stat_in=3'd1 -> identical values next edge, valid_out=1.
- Stall 3 cycles with changing inputs -> outputs frozen at the prior values. stall_cnt=3 (PERF_EN) else 0. No timeout with STALL_MAX=15.
- Bubble one edge after a load -> nop values, valid_out=0, bubble_cnt=1. Load next edge -> new instruction, valid_out=1.
- stall=1 and bubble=1 together -> outputs hold, ctrl_conflict=1 and sticky after both drop.
- Stall 15 consecutive edges -> stall_timeout=1 after the 15th. Release then rst_n=0 -> timeout=0.
